update_scheduler: RTL
=====================

# update_scheduler

Sequences the snake game's per-tick update. It generates the game update period from a programmable, level-dependent cycle count and drives a two-phase start/done handshake, MOVE then CHECK, with the game logic. It also tracks food eaten to raise the speed level, supports pause, and halts on game over. It sits between the top-level clock and the movement/collision logic.

## Interface
- BASE_PERIOD, 12500000: update period in clk cycles at level 0
- STEP, 1000000: period reduction per level
- MIN_PERIOD, 2500000: floor on the period
- FOODS_PER_LEVEL, 4: food events per level increment
- MAX_LEVEL, 10: level saturation value
- CNT_W, 24: counter/period width
- LEVEL_W, 4: level width
- clk  in  1  system clock; the only clock
- rst  in  1  synchronous, active-high reset
- pause  in  1  level; freezes the period counter while high
- food_eaten  in  1  one-cycle pulse from collision logic
- game_over  in  1  level; sampled only together with check_done
- move_done  in  1  movement logic finished the MOVE phase
- check_done  in  1  collision/food logic finished the CHECK phase
- move_start  out  1  one-cycle pulse that starts MOVE
- check_start  out  1  one-cycle pulse that starts CHECK
- busy  out  1  high in MOVE or CHECK
- halted  out  1  high in HALT
- level  out  LEVEL_W  current speed level

## Operation
- States: COUNT, MOVE, CHECK, HALT. Reset state is COUNT.
- COUNT:
  - cnt increments each cycle pause is low and holds while pause is high.
  - When cnt >= period-1 and pause is low: cnt<=0, state<=MOVE, move_start<=1 for one cycle.
- MOVE:
  - Wait for move_done, then state<=CHECK and check_start<=1 for one cycle.
  - move_done sampled in the same cycle as move_start is ignored.
- CHECK:
  - Wait for check_done.
  - If game_over=1 in that cycle, state<=HALT; else state<=COUNT with cnt=0.
- HALT: all outputs idle except halted=1; remains until rst.
- pause affects COUNT only. MOVE/CHECK handshakes complete regardless.
- Food/level logic:
  - fcnt counts food_eaten in every state except HALT.
  - On the FOODS_PER_LEVEL-th pulse: fcnt<=0, and level<=level+1, saturating at MAX_LEVEL.
- Period:
  - period = max(BASE_PERIOD - level*STEP, MIN_PERIOD).
  - Compute it in CNT_W+LEVEL_W bits so the subtraction cannot underflow, then clamp.
  - It is registered and updates one cycle after level changes.
- A period shrink mid-count with cnt already >= new period-1 expires on the next eligible cycle, with no wrap.
- Reset values: move_start=0, check_start=0, busy=0, halted=0, level=0, cnt=0, fcnt=0, period=BASE_PERIOD.
- rst in any state, including mid-handshake, returns all of the above on the next edge. Pending done inputs are discarded.

## Timing
- After reset release, cnt=0 in the first cycle. move_start is high in cycle `period`, counted from 0.
- check_start: the cycle after move_done is sampled high.
- Return to COUNT: the cycle after check_done. The next move_start follows `period` unpaused cycles later.
- Each pause cycle in COUNT delays move_start by exactly one cycle.
- level changes the cycle after the qualifying food_eaten. period changes one cycle after that.

## Configuration
- SPEEDUP_EN defined: level/food logic and the period formula are compiled in as above.
- SPEEDUP_EN undefined: fcnt and the level register are removed, level is tied to 0, period is constant BASE_PERIOD, and food_eaten is ignored.

## Structure
- Shared package snake_pkg holds:
  - the state encoding (COUNT, MOVE, CHECK, HALT)
  - the default BASE_PERIOD, STEP and MIN_PERIOD constants
- One sub-module, update_period: computes the registered, clamped period from level. It is instantiated only under SPEEDUP_EN.

## Test plan
All tests use BASE_PERIOD=10, STEP=2, MIN_PERIOD=4, FOODS_PER_LEVEL=2, MAX_LEVEL=3, SPEEDUP_EN defined.
- Release rst; responders assert done the cycle after each start:
  - move_start at cycle 10, check_start at cycle 12.
  - COUNT re-entered at cycle 14; next move_start at cycle 24.
- Pause held 5 cycles at cnt=3 -> move_start arrives at cycle 15 instead of 10; busy stays 0 throughout the pause.
- Food pulses:
  - 2 pulses -> level=1, period=8.
  - 6 pulses -> level=3, period=4.
  - 8 pulses -> level stays 3, period stays 4.
- game_over=1 with check_done -> halted=1, no move_start for 100 cycles; rst -> halted=0, level=0.
- With cnt=8 at level 0, two food pulses (period becomes 8) -> move_start on the next eligible cycle, with no counter wrap.
- rst asserted in MOVE with move_done pending -> next cycle busy=0, move_start=0, level=0; a late move_done is ignored.

Source files
------------

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared state encoding and default timing constants for the snake update path

package snake_pkg;

  typedef enum logic [1:0] {
    COUNT = 2'd0,
    MOVE  = 2'd1,
    CHECK = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam int DEFAULT_BASE_PERIOD = 12500000;
  localparam int DEFAULT_STEP        = 1000000;
  localparam int DEFAULT_MIN_PERIOD  = 2500000;

endpackage

// File: rtl/update_period.sv
// rtl/update_period.sv - registered, clamped update period derived from the speed level

module update_period
  import snake_pkg::*;
#(
  parameter int BASE_PERIOD = DEFAULT_BASE_PERIOD,
  parameter int STEP        = DEFAULT_STEP,
  parameter int MIN_PERIOD  = DEFAULT_MIN_PERIOD,
  parameter int CNT_W       = 24,
  parameter int LEVEL_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LEVEL_W-1:0] level,
  output logic [CNT_W-1:0]   period
);

  localparam int W = CNT_W + LEVEL_W;

  logic [W-1:0] base_w;
  logic [W-1:0] min_w;
  logic [W-1:0] reduction;
  logic [W-1:0] clamped;

  // Widened so level*STEP can exceed the base without the difference wrapping.
  always_comb begin
    base_w    = W'(BASE_PERIOD);
    min_w     = W'(MIN_PERIOD);
    reduction = W'(level) * W'(STEP);
    clamped   = min_w;
    if ((reduction < base_w) && ((base_w - reduction) > min_w)) begin
      clamped = base_w - reduction;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period <= CNT_W'(BASE_PERIOD);
    end else begin
      period <= clamped[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/update_scheduler.sv
// rtl/update_scheduler.sv - game tick generator with MOVE/CHECK handshake; SPEEDUP_EN enables food-driven levels

module update_scheduler
  import snake_pkg::*;
#(
  parameter int BASE_PERIOD     = DEFAULT_BASE_PERIOD,
  parameter int STEP            = DEFAULT_STEP,
  parameter int MIN_PERIOD      = DEFAULT_MIN_PERIOD,
  parameter int FOODS_PER_LEVEL = 4,
  parameter int MAX_LEVEL       = 10,
  parameter int CNT_W           = 24,
  parameter int LEVEL_W         = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pause,
  input  logic               food_eaten,
  input  logic               game_over,
  input  logic               move_done,
  input  logic               check_done,
  output logic               move_start,
  output logic               check_start,
  output logic               busy,
  output logic               halted,
  output logic [LEVEL_W-1:0] level
);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period;
  logic             move_start_q;
  logic             check_start_q;
  logic             expire;
  logic             move_ack;

  // >= rather than == so a period that shrinks below cnt still fires instead of wrapping.
  assign expire   = (state == COUNT) && !pause && (cnt >= (period - CNT_W'(1)));
  assign move_ack = (state == MOVE) && move_done && !move_start_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= COUNT;
      cnt           <= '0;
      move_start_q  <= 1'b0;
      check_start_q <= 1'b0;
    end else begin
      state         <= state_nx;
      move_start_q  <= expire;
      check_start_q <= move_ack;
      if (state == COUNT && !pause) begin
        cnt <= expire ? '0 : cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      COUNT: if (expire) state_nx = MOVE;
      MOVE:  if (move_ack) state_nx = CHECK;
      CHECK: if (check_done) state_nx = game_over ? HALT : COUNT;
      HALT:  state_nx = HALT;
      default: state_nx = COUNT;
    endcase
  end

  always_comb begin
    move_start  = move_start_q;
    check_start = check_start_q;
    busy        = (state == MOVE) || (state == CHECK);
    halted      = (state == HALT);
  end

`ifdef SPEEDUP_EN
  localparam int FCNT_W = (FOODS_PER_LEVEL > 1) ? $clog2(FOODS_PER_LEVEL) : 1;

  logic [FCNT_W-1:0]  fcnt;
  logic [LEVEL_W-1:0] level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt    <= '0;
      level_q <= '0;
    end else if (food_eaten && state != HALT) begin
      if (fcnt == FCNT_W'(FOODS_PER_LEVEL - 1)) begin
        fcnt <= '0;
        if (level_q < LEVEL_W'(MAX_LEVEL)) begin
          level_q <= level_q + LEVEL_W'(1);
        end
      end else begin
        fcnt <= fcnt + FCNT_W'(1);
      end
    end
  end

  update_period #(
    .BASE_PERIOD(BASE_PERIOD),
    .STEP       (STEP),
    .MIN_PERIOD (MIN_PERIOD),
    .CNT_W      (CNT_W),
    .LEVEL_W    (LEVEL_W)
  ) u_period (
    .clk   (clk),
    .rst   (rst),
    .level (level_q),
    .period(period)
  );

  assign level = level_q;
`else
  localparam int unused_cfg = FOODS_PER_LEVEL + MAX_LEVEL + STEP + MIN_PERIOD;
  logic unused_food;

  assign unused_food = food_eaten;
  assign period      = CNT_W'(BASE_PERIOD);
  assign level       = '0;
`endif

endmodule
